// File: rtl/forthsuper_pkg.sv
// rtl/forthsuper_pkg.sv - shared stack opcode, FSM state and response types
package forthsuper_pkg;

  // Stack operations presented on the op port
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5
  } stack_op_t;

  // Controller sequencing: POP deeper than the cached pair needs a RAM refill
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_LD   = 2'd2
  } stack_state_t;

  // Completion response: ack with its coincident error flags
  typedef struct packed {
    logic ack;
    logic err_ovf;
    logic err_unf;
  } stack_resp_t;

  localparam stack_resp_t RESP_NONE = '{ack: 1'b0, err_ovf: 1'b0, err_unf: 1'b0};
  localparam stack_resp_t RESP_OK   = '{ack: 1'b1, err_ovf: 1'b0, err_unf: 1'b0};
  localparam stack_resp_t RESP_OVF  = '{ack: 1'b1, err_ovf: 1'b1, err_unf: 1'b0};
  localparam stack_resp_t RESP_UNF  = '{ack: 1'b1, err_ovf: 1'b0, err_unf: 1'b1};

  // Ops that add one item and may spill nos into RAM
  function automatic logic op_grows(stack_op_t op);
    return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

  // Minimum item count an op needs before it may execute
  function automatic logic [1:0] op_min_depth(stack_op_t op);
    case (op)
      OP_POP, OP_DUP:   return 2'd1;
      OP_SWAP, OP_OVER: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - single-port stack RAM, registered read
module stack_ram #(
  parameter int DSZ = 32,
  parameter int SSZ = 6
) (
  input  logic           clk,
  input  logic [SSZ-1:0] addr,
  input  logic           we,
  input  logic [DSZ-1:0] wd,
  output logic [DSZ-1:0] rd
);

  logic [DSZ-1:0] mem [0:(1<<SSZ)-1];

  // Write on we; read data is the addressed word one cycle later
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    rd <= mem[addr];
  end

endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack controller with cached tos/nos and RAM spill/refill
module stack_ctrl
  import forthsuper_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           req,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic           ack,
  output logic           busy,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [SSZ:0]   depth,
  output logic           err_ovf,
  output logic           err_unf,
  output logic [SSZ-1:0] ram_addr,
  output logic           ram_we,
  output logic [DSZ-1:0] ram_wd,
  input  logic [DSZ-1:0] ram_rd
);

  localparam logic [SSZ:0] DEPTH_MAX = (SSZ+1)'(DEPTH);
  localparam logic [SSZ:0] ONE       = (SSZ+1)'(1);
  localparam logic [SSZ:0] TWO       = (SSZ+1)'(2);
  localparam logic [SSZ:0] THREE     = (SSZ+1)'(3);

  stack_state_t   state;
  stack_resp_t    resp;
  stack_op_t      op_e;
  logic           accept;
  logic           is_ovf;
  logic           is_unf;
  logic [DSZ-1:0] grow_tos;

  assign op_e    = stack_op_t'(op);
  assign ack     = resp.ack;
  assign err_ovf = resp.err_ovf;
  assign err_unf = resp.err_unf;

  // Accept decode: blocked during the ack cycle so a held req is not replayed
  always_comb begin
    accept   = !rst && en && req && (state == S_IDLE) && !resp.ack;
    is_ovf   = op_grows(op_e) && (depth == DEPTH_MAX);
    is_unf   = depth < (SSZ+1)'(op_min_depth(op_e));
    grow_tos = vi;
    case (op_e)
      OP_DUP:  grow_tos = tos;
      OP_OVER: grow_tos = nos;
      default: grow_tos = vi;
    endcase
  end

  // RAM port: item 3 lives at depth-2 after a push and after a pop's decrement
  always_comb begin
    ram_addr = SSZ'(depth - TWO);
    ram_wd   = nos;
    ram_we   = accept && op_grows(op_e) && !is_ovf && !is_unf && (depth >= TWO);
  end

  // Controller FSM with registered response, busy and cached stack top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      resp  <= RESP_NONE;
      busy  <= 1'b0;
      depth <= '0;
      tos   <= '0;
      nos   <= '0;
    end else begin
      resp <= RESP_NONE;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_ovf) begin
              resp <= RESP_OVF;
            end else if (is_unf) begin
              resp <= RESP_UNF;
            end else begin
              case (op_e)
                OP_PUSH, OP_DUP, OP_OVER: begin
                  tos   <= grow_tos;
                  nos   <= tos;
                  depth <= depth + ONE;
                  resp  <= RESP_OK;
                end
                OP_SWAP: begin
                  tos  <= nos;
                  nos  <= tos;
                  resp <= RESP_OK;
                end
                OP_POP: begin
                  tos   <= nos;
                  depth <= depth - ONE;
                  if (depth >= THREE) begin
                    state <= S_RD;
                    busy  <= 1'b1;
                  end else begin
                    resp <= RESP_OK;
                  end
                end
                default: resp <= RESP_OK;
              endcase
            end
          end
        end
        S_RD: begin
          if (en) begin
            state <= S_LD;
          end
        end
        S_LD: begin
          if (en) begin
            nos   <= ram_rd;
            resp  <= RESP_OK;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed table-driven bench for stack_ctrl with stack_ram
module tb_stack_ctrl;
  import forthsuper_pkg::*;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int SSZ   = 6;

  logic           clk;
  logic           rst;
  logic           en;
  logic           req;
  logic [2:0]     op;
  logic [DSZ-1:0] vi;
  logic           ack;
  logic           busy;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] nos;
  logic [SSZ:0]   depth;
  logic           err_ovf;
  logic           err_unf;
  logic [SSZ-1:0] ram_addr;
  logic           ram_we;
  logic [DSZ-1:0] ram_wd;
  logic [DSZ-1:0] ram_rd;

  stack_ctrl #(.DEPTH(DEPTH), .DSZ(DSZ), .SSZ(SSZ)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .op(op), .vi(vi),
    .ack(ack), .busy(busy), .tos(tos), .nos(nos), .depth(depth),
    .err_ovf(err_ovf), .err_unf(err_unf),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  stack_ram #(.DSZ(DSZ), .SSZ(SSZ)) u_ram (
    .clk(clk), .addr(ram_addr), .we(ram_we), .wd(ram_wd), .rd(ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] vi, lat, tos, nos, depth, ovf, unf;
    int          ram_a;
    logic [31:0] ram_v;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] got_lat;
  logic        got_ovf, got_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] o, input int v, input int l, input int t, input int n,
                     input int d, input int ov, input int un, input int ra, input int rv);
    vec_t r;
    r.op = o; r.vi = 32'(v); r.lat = 32'(l); r.tos = 32'(t); r.nos = 32'(n);
    r.depth = 32'(d); r.ovf = 32'(ov); r.unf = 32'(un); r.ram_a = ra; r.ram_v = 32'(rv);
    tbl.push_back(r);
  endtask

  task automatic wait_no_ack();
    @(negedge clk);
    for (int k = 0; k < 4 && ack; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op, hold req until ack, check busy and RAM-write quiet while waiting
  task automatic do_op(input logic [2:0] o, input logic [DSZ-1:0] v, input int exp_lat);
    int  n;
    logic done;
    wait_no_ack();
    op = o; vi = v; req = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack) done = 1'b1;
      else begin
        chk("busy_wait", 32'(busy), 32'd1);
        chk("we_in_rd_ld", 32'(ram_we), 32'd0);
      end
    end
    got_ovf = err_ovf;
    got_unf = err_unf;
    got_lat = done ? 32'(n) : 32'hffff_ffff;
    req = 1'b0;
    chk($sformatf("latency_op%0d", o), got_lat, 32'(exp_lat));
  endtask

  initial begin
    int n, first_ack, second_ack;
    rst = 1'b1; en = 1'b1; req = 1'b1; op = 3'(OP_PUSH); vi = 32'hdead;

    // Reset state, with a request pending that must not leak through
    repeat (2) @(negedge clk);
    chk("rst_tos", tos, 0);
    chk("rst_nos", nos, 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", 32'({err_ovf, err_unf}), 0);
    chk("rst_we", 32'(ram_we), 0);
    req = 1'b0;
    rst = 1'b0;

    //   op       vi lat tos nos d ovf unf ram_a ram_v
    add(OP_PUSH,  1, 1,  1,  0, 1, 0, 0, -1, 0);
    add(OP_PUSH,  2, 1,  2,  1, 2, 0, 0, -1, 0);
    add(OP_PUSH,  3, 1,  3,  2, 3, 0, 0,  0, 1);
    add(OP_PUSH,  4, 1,  4,  3, 4, 0, 0,  1, 2);
    add(OP_POP,   0, 3,  3,  2, 3, 0, 0, -1, 0);
    add(OP_SWAP,  0, 1,  2,  3, 3, 0, 0, -1, 0);
    add(OP_POP,   0, 3,  3,  1, 2, 0, 0, -1, 0);
    add(OP_POP,   0, 1,  1,  1, 1, 0, 0, -1, 0);
    add(OP_SWAP,  0, 1,  1,  1, 1, 0, 1, -1, 0);
    add(OP_OVER,  0, 1,  1,  1, 1, 0, 1, -1, 0);
    add(OP_POP,   0, 1,  1,  1, 0, 0, 0, -1, 0);
    add(OP_POP,   0, 1,  1,  1, 0, 0, 1, -1, 0);
    add(OP_DUP,   0, 1,  1,  1, 0, 0, 1, -1, 0);
    add(OP_PUSH,  9, 1,  9,  1, 1, 0, 0, -1, 0);
    add(OP_PUSH,  7, 1,  7,  9, 2, 0, 0, -1, 0);
    add(OP_SWAP,  0, 1,  9,  7, 2, 0, 0, -1, 0);
    add(OP_OVER,  0, 1,  7,  9, 3, 0, 0,  0, 7);
    add(OP_DUP,   0, 1,  7,  7, 4, 0, 0,  1, 9);
    add(OP_POP,   0, 3,  7,  9, 3, 0, 0, -1, 0);
    add(OP_NOP,   0, 1,  7,  9, 3, 0, 0, -1, 0);
    add(3'd7,     0, 1,  7,  9, 3, 0, 0, -1, 0);

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].vi, int'(tbl[i].lat));
      chk($sformatf("v%0d_tos", i), tos, tbl[i].tos);
      chk($sformatf("v%0d_nos", i), nos, tbl[i].nos);
      chk($sformatf("v%0d_depth", i), 32'(depth), tbl[i].depth);
      chk($sformatf("v%0d_ovf", i), 32'(got_ovf), tbl[i].ovf);
      chk($sformatf("v%0d_unf", i), 32'(got_unf), tbl[i].unf);
      if (tbl[i].ram_a >= 0) begin
        @(negedge clk);
        chk($sformatf("v%0d_ram", i), u_ram.mem[SSZ'(tbl[i].ram_a)], tbl[i].ram_v);
      end
    end

    // Held req: second PUSH accepted the cycle after the first ack
    wait_no_ack();
    op = 3'(OP_PUSH); vi = 32'h11; req = 1'b1;
    first_ack = -1; second_ack = -1;
    for (int c = 1; c <= 10 && second_ack < 0; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        if (first_ack < 0) first_ack = c;
        else second_ack = c;
      end
    end
    req = 1'b0;
    chk("held_first_ack", 32'(first_ack), 1);
    chk("held_second_ack", 32'(second_ack), 3);
    chk("held_depth", 32'(depth), 5);
    chk("held_tos", tos, 32'h11);
    chk("held_nos", nos, 32'h11);

    // Fill to DEPTH, overflow, then drain through the RAM and underflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) do_op(3'(OP_PUSH), 32'(i), 1);
    chk("full_depth", 32'(depth), 32'(DEPTH));
    do_op(3'(OP_PUSH), 32'h55, 1);
    chk("ovf_flag", 32'(got_ovf), 1);
    chk("ovf_unf_flag", 32'(got_unf), 0);
    chk("ovf_depth", 32'(depth), 32'(DEPTH));
    chk("ovf_tos", tos, 32'(DEPTH));
    do_op(3'(OP_DUP), 0, 1);
    chk("ovf_dup_flag", 32'(got_ovf), 1);
    chk("ovf_dup_nos", nos, 32'(DEPTH - 1));
    for (int d = DEPTH; d >= 1; d--) begin
      do_op(3'(OP_POP), 0, (d >= 3) ? 3 : 1);
      chk($sformatf("drain%0d_depth", d), 32'(depth), 32'(d - 1));
      if (d - 1 >= 1) chk($sformatf("drain%0d_tos", d), tos, 32'(d - 1));
      if (d - 1 >= 2) chk($sformatf("drain%0d_nos", d), nos, 32'(d - 2));
    end
    do_op(3'(OP_POP), 0, 1);
    chk("unf_flag", 32'(got_unf), 1);
    chk("unf_depth", 32'(depth), 0);

    // Reset during RD of a POP
    do_reset();
    do_op(3'(OP_PUSH), 10, 1);
    do_op(3'(OP_PUSH), 20, 1);
    do_op(3'(OP_PUSH), 30, 1);
    wait_no_ack();
    op = 3'(OP_POP); req = 1'b1;
    @(posedge clk); #1;
    chk("rdrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rdrst_depth", 32'(depth), 0);
    chk("rdrst_busy", 32'(busy), 0);
    chk("rdrst_ack", 32'(ack), 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(3'(OP_PUSH), 5, 1);
    chk("rdrst_push_tos", tos, 5);
    chk("rdrst_push_depth", 32'(depth), 1);

    // en low for 3 cycles while in RD
    do_reset();
    do_op(3'(OP_PUSH), 10, 1);
    do_op(3'(OP_PUSH), 20, 1);
    do_op(3'(OP_PUSH), 30, 1);
    wait_no_ack();
    op = 3'(OP_POP); req = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("enlo_ack", 32'(ack), 0);
      chk("enlo_busy", 32'(busy), 1);
      chk("enlo_depth", 32'(depth), 2);
    end
    en = 1'b1;
    n = 0;
    while (!ack && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    chk("enlo_resume_cycles", 32'(n), 2);
    chk("enlo_tos", tos, 20);
    chk("enlo_nos", nos, 10);
    chk("enlo_final_depth", 32'(depth), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
